// File: rtl/rf_scoreboard.sv
// Register-write scoreboard: per-register pending-write counters covering
// the window from issue (ID->EX) to retirement (register-file write port).
// Drives the decode-stage STALL for RAW hazards and flags protocol errors.
module rf_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ISSUE_VALID,
  input  logic             ISSUE_WE,
  input  logic [4:0]       ISSUE_RD,
  input  logic             SRC1_USE,
  input  logic [4:0]       SRC1_ADR,
  input  logic             SRC2_USE,
  input  logic [4:0]       SRC2_ADR,
  input  logic             WB_EN,
  input  logic [4:0]       WB_WA,
  output logic             STALL,
  output logic [NREGS-1:0] BUSY_MASK,
  output logic [6:0]       INFLIGHT,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [6:0]       inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             stall;
  logic             issue_acc;
  logic             ret_acc;
  logic             same_reg;

  // Decode hold: a used, non-zero source with a pending write. A retirement in
  // the same cycle does not release it; the RF write only lands at the edge.
  always_comb begin
    stall = 1'b0;
    if (SRC1_USE && (SRC1_ADR != '0) && (cnt_q[SRC1_ADR] != '0)) stall = 1'b1;
    if (SRC2_USE && (SRC2_ADR != '0) && (cnt_q[SRC2_ADR] != '0)) stall = 1'b1;
  end

  assign issue_acc = ISSUE_VALID & ~stall & ISSUE_WE & (ISSUE_RD != '0);
  assign ret_acc   = WB_EN & (WB_WA != '0);
  // Issue and retire of the same register cancel out.
  assign same_reg  = issue_acc & ret_acc & (ISSUE_RD == WB_WA);

  // Counter, total and error next-state with saturate/underflow suppression.
  always_comb begin
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    busy_d     = '0;
    if (issue_acc && !same_reg) begin
      if (cnt_q[ISSUE_RD] == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d[ISSUE_RD] = cnt_q[ISSUE_RD] + CNT_W'(1);
        inflight_d      = inflight_d + 7'd1;
      end
    end
    if (ret_acc && !same_reg) begin
      if (cnt_q[WB_WA] == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d[WB_WA] = cnt_q[WB_WA] - CNT_W'(1);
        inflight_d   = inflight_d - 7'd1;
      end
    end
    for (int unsigned i = 1; i < NREGS; i++) begin
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // State registers; reset discards every reservation immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '{default: '0};
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign STALL     = stall;
  assign BUSY_MASK = busy_q;
  assign INFLIGHT  = inflight_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: hand-computed vector table,
// hand-written error/reset sequences, and random traffic against a
// count-per-register reference model.
module tb_rf_scoreboard;

  logic        CLK;
  logic        RST_N;
  logic        ISSUE_VALID, ISSUE_WE;
  logic [4:0]  ISSUE_RD;
  logic        SRC1_USE, SRC2_USE;
  logic [4:0]  SRC1_ADR, SRC2_ADR;
  logic        WB_EN;
  logic [4:0]  WB_WA;
  logic        STALL;
  logic [31:0] BUSY_MASK;
  logic [6:0]  INFLIGHT;
  logic        ERR;

  int n_chk  = 0;
  int n_fail = 0;

  rf_scoreboard #(.NREGS(32), .CNT_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_WE(ISSUE_WE), .ISSUE_RD(ISSUE_RD),
    .SRC1_USE(SRC1_USE), .SRC1_ADR(SRC1_ADR),
    .SRC2_USE(SRC2_USE), .SRC2_ADR(SRC2_ADR),
    .WB_EN(WB_EN), .WB_WA(WB_WA),
    .STALL(STALL), .BUSY_MASK(BUSY_MASK), .INFLIGHT(INFLIGHT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit        v, we;
    bit [4:0]  rd;
    bit        u1;
    bit [4:0]  a1;
    bit        u2;
    bit [4:0]  a2;
    bit        en;
    bit [4:0]  wa;
    bit        exp_stall;
    bit [31:0] exp_busy;
    int        exp_infl;
    bit        exp_err;
  } vec_t;

  function automatic vec_t mk(bit v, bit we, bit [4:0] rd, bit u1, bit [4:0] a1,
                              bit u2, bit [4:0] a2, bit en, bit [4:0] wa,
                              bit es, bit [31:0] eb, int ei, bit ee);
    vec_t x;
    x.v = v; x.we = we; x.rd = rd; x.u1 = u1; x.a1 = a1; x.u2 = u2; x.a2 = a2;
    x.en = en; x.wa = wa; x.exp_stall = es; x.exp_busy = eb; x.exp_infl = ei;
    x.exp_err = ee;
    return x;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    ISSUE_VALID = x.v; ISSUE_WE = x.we; ISSUE_RD = x.rd;
    SRC1_USE = x.u1; SRC1_ADR = x.a1; SRC2_USE = x.u2; SRC2_ADR = x.a2;
    WB_EN = x.en; WB_WA = x.wa;
  endtask

  // Drive one cycle, check STALL mid-cycle and registered outputs after the edge.
  task automatic apply(input string nm, input vec_t x);
    drive(x);
    #1;
    chk({nm, "_stall"}, STALL, x.exp_stall);
    @(posedge CLK);
    #1;
    chk({nm, "_busy"}, BUSY_MASK, x.exp_busy);
    chk({nm, "_infl"}, INFLIGHT, x.exp_infl);
    chk({nm, "_err"}, ERR, x.exp_err);
  endtask

  // Reference model: number of writes in flight per architectural register.
  int m_cnt [32];
  int m_infl;
  bit m_err;

  function automatic void m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_infl = 0;
    m_err  = 1'b0;
  endfunction

  function automatic bit m_stall(vec_t x);
    return (x.u1 && x.a1 != 0 && m_cnt[x.a1] > 0) ||
           (x.u2 && x.a2 != 0 && m_cnt[x.a2] > 0);
  endfunction

  function automatic void m_step(vec_t x);
    bit iss, ret;
    iss = x.v && !m_stall(x) && x.we && x.rd != 0;
    ret = x.en && x.wa != 0;
    if (iss && ret && x.rd == x.wa) return;
    if (iss) begin
      if (m_cnt[x.rd] == 3) m_err = 1'b1;
      else begin m_cnt[x.rd]++; m_infl++; end
    end
    if (ret) begin
      if (m_cnt[x.wa] == 0) m_err = 1'b1;
      else begin m_cnt[x.wa]--; m_infl--; end
    end
  endfunction

  function automatic bit [31:0] m_busy();
    bit [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  vec_t idle;
  vec_t tbl [$];

  initial begin
    idle = mk(0,0,0, 0,0, 0,0, 0,0, 0,'0,0,0);

    // Reset held with random inputs: everything reads zero.
    RST_N = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ISSUE_VALID = 1'($urandom); ISSUE_WE = 1'($urandom); ISSUE_RD = 5'($urandom);
      SRC1_USE = 1'($urandom); SRC1_ADR = 5'($urandom);
      SRC2_USE = 1'($urandom); SRC2_ADR = 5'($urandom);
      WB_EN = 1'($urandom); WB_WA = 5'($urandom);
      @(posedge CLK);
      #1;
      chk("rst_stall", STALL, 0);
      chk("rst_busy", BUSY_MASK, 0);
      chk("rst_infl", INFLIGHT, 0);
      chk("rst_err", ERR, 0);
    end
    drive(idle);
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) apply("post_rst", idle);

    // Hand-computed vectors: RAW, x0/masking, multiple writers, simultaneous.
    //            v we rd  u1 a1  u2 a2  en wa   stall busy         infl err
    tbl.push_back(mk(1,1,5,  0,0,  0,0,  0,0,  0, 32'h0000_0020, 1, 0));
    tbl.push_back(mk(1,1,9,  1,5,  0,0,  0,0,  1, 32'h0000_0020, 1, 0));
    tbl.push_back(mk(0,0,0,  1,5,  0,0,  0,0,  1, 32'h0000_0020, 1, 0));
    tbl.push_back(mk(0,0,0,  1,5,  0,0,  1,5,  1, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(0,0,0,  1,5,  0,0,  0,0,  0, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1,1,0,  1,0,  0,0,  0,0,  0, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1,1,6,  0,0,  0,6,  0,0,  0, 32'h0000_0040, 1, 0));
    tbl.push_back(mk(0,0,0,  0,0,  0,6,  0,0,  0, 32'h0000_0040, 1, 0));
    tbl.push_back(mk(0,0,0,  0,0,  1,6,  1,6,  1, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0, 32'h0000_0080, 1, 0));
    tbl.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0, 32'h0000_0080, 2, 0));
    tbl.push_back(mk(0,0,0,  0,0,  0,0,  1,7,  0, 32'h0000_0080, 1, 0));
    tbl.push_back(mk(0,0,0,  0,0,  0,0,  1,7,  0, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1,1,8,  0,0,  0,0,  0,0,  0, 32'h0000_0100, 1, 0));
    tbl.push_back(mk(1,1,8,  0,0,  0,0,  1,8,  0, 32'h0000_0100, 1, 0));
    tbl.push_back(mk(1,1,9,  0,0,  0,0,  1,8,  0, 32'h0000_0200, 1, 0));
    tbl.push_back(mk(0,0,0,  0,0,  0,0,  1,9,  0, 32'h0000_0000, 0, 0));
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Saturation: four issues to x3, the fourth sets ERR and is dropped.
    apply("sat1", mk(1,1,3, 0,0, 0,0, 0,0, 0, 32'h8, 1, 0));
    apply("sat2", mk(1,1,3, 0,0, 0,0, 0,0, 0, 32'h8, 2, 0));
    apply("sat3", mk(1,1,3, 0,0, 0,0, 0,0, 0, 32'h8, 3, 0));
    apply("sat4", mk(1,1,3, 0,0, 0,0, 0,0, 0, 32'h8, 3, 1));
    apply("unf_a", mk(0,0,0, 0,0, 0,0, 1,10, 0, 32'h8, 3, 1));

    // Asynchronous reset mid-cycle while x3 is stalling decode.
    drive(mk(0,0,0, 1,3, 0,0, 0,0, 0,'0,0,0));
    #1;
    chk("mid_pre_stall", STALL, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_stall", STALL, 0);
    chk("mid_busy", BUSY_MASK, 0);
    chk("mid_infl", INFLIGHT, 0);
    chk("mid_err", ERR, 0);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_idle_busy", BUSY_MASK, 0);
    apply("post_mid", mk(1,1,4, 0,0, 0,0, 0,0, 0, 32'h10, 1, 0));
    apply("unf_b",    mk(0,0,0, 0,0, 0,0, 1,10, 0, 32'h10, 1, 1));

    // Random traffic on x0..x7 against the reference model.
    for (int c = 0; c < 3000; c++) begin
      vec_t x;
      bit es;
      if (c % 400 == 0) begin
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        m_reset();
      end
      x = idle;
      x.v  = ($urandom_range(0, 3) != 0);
      x.we = ($urandom_range(0, 3) != 0);
      x.rd = 5'($urandom_range(0, 7));
      x.u1 = 1'($urandom); x.a1 = 5'($urandom_range(0, 7));
      x.u2 = 1'($urandom); x.a2 = 5'($urandom_range(0, 7));
      x.en = 1'($urandom);
      x.wa = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) begin
        int off = $urandom_range(0, 6);
        for (int k = 0; k < 7; k++) begin
          int j = 1 + ((off + k) % 7);
          if (m_cnt[j] > 0) begin x.wa = 5'(j); break; end
        end
      end
      es = m_stall(x);
      drive(x);
      #1;
      chk("rnd_stall", STALL, es);
      m_step(x);
      @(posedge CLK);
      #1;
      chk("rnd_busy", BUSY_MASK, m_busy());
      chk("rnd_infl", INFLIGHT, m_infl);
      chk("rnd_err", ERR, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-write scoreboard for the OTTER 5-stage pipeline. It tracks destination registers with writes in flight, from issue at the ID→EX boundary to retirement at the register-file write port. It drives the decode-stage STALL for read-after-write hazards that forwarding cannot cover. It is the writer-side counterpart to the register file: it predicts every RF_EN/RF_WA write before it lands and releases the reservation when it does.

## Interface
- NREGS, 32: number of architectural registers; index 0 is hard-wired zero.
- CNT_W, 2: width of each per-register pending counter; saturates at 2^CNT_W−1 (3).
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- ISSUE_VALID  in  1  decode presents an instruction for issue this cycle.
- ISSUE_WE  in  1  issuing instruction writes a destination register.
- ISSUE_RD  in  5  destination register of issuing instruction.
- SRC1_USE, SRC2_USE  in  1 each  decode instruction reads rs1 / rs2.
- SRC1_ADR, SRC2_ADR  in  5 each  rs1 / rs2 addresses.
- WB_EN  in  1  retirement write; same signal and cycle as RF_EN.
- WB_WA  in  5  retirement address; same as RF_WA.
- STALL  out  1  decode must hold; the instruction is not issued.
- BUSY_MASK  out  NREGS  bit i = register i has ≥1 pending write (registered).
- INFLIGHT  out  7  total outstanding tracked writes (registered).
- ERR  out  1  sticky protocol error flag (registered).

## Operation
- State: one CNT_W-bit counter per register 1..NREGS−1. Register 0 has no counter and is never busy.
- STALL (combinational) = (SRC1_USE & SRC1_ADR≠0 & cnt[SRC1_ADR]≠0) | (SRC2_USE & SRC2_ADR≠0 & cnt[SRC2_ADR]≠0).
- A same-cycle retirement does NOT clear STALL. The RF write lands at the clock edge, so the same-cycle read returns the old value.
- issue_acc = ISSUE_VALID & ~STALL & ISSUE_WE & ISSUE_RD≠0. ISSUE_VALID while STALL=1 is ignored, with no state change.
- ret_acc = WB_EN & WB_WA≠0.
- Per-register next count:
  - issue_acc to reg r and no ret_acc to r: +1.
  - ret_acc to r and no issue_acc to r: −1.
  - Both to the same r: unchanged.
  - Issue and retire to different registers: both apply in the same cycle.
- Saturation: issue_acc to r when cnt[r]=3 and no same-cycle retire of r → count stays 3, ERR←1.
- Underflow: ret_acc to r when cnt[r]=0 and no same-cycle issue to r → count stays 0, ERR←1.
- BUSY_MASK[i] = (cnt[i]≠0) from the updated counters. BUSY_MASK[0] is always 0.
- INFLIGHT tracks the sum of all counters, incremented and decremented with the same saturate/underflow suppression.
- ERR is cleared only by reset.
- No flush port. Squashed IF/ID instructions are never issued, and issued instructions always retire.

## Timing
- Reset (RST_N=0, asynchronous): all counters 0, BUSY_MASK=0, INFLIGHT=0, ERR=0. STALL therefore evaluates to 0.
- Reset mid-operation discards all reservations immediately. The first edge after deassertion is a normal update.
- Issue at edge n → BUSY_MASK/STALL reflect it from cycle n+1.
- Retire at edge n → release visible from cycle n+1. STALL for that register is high during cycle n and low in cycle n+1.
- STALL has zero-cycle latency from the SRC*/USE inputs. Counter-to-STALL is a combinational path within the ID stage.
- Minimum RAW stall for a non-forwarded dependency is 3 cycles (EX, MEM, WB).

## Test plan
- Reset: hold RST_N=0 with random inputs. Expected: STALL=0, BUSY_MASK=0, INFLIGHT=0, ERR=0. Release RST_N; outputs are unchanged until the first issue.
- Basic RAW: issue x5 (cycle 0). From cycle 1, SRC1_ADR=5, SRC1_USE=1 → STALL=1. WB_EN=1, WB_WA=5 in cycle 3 → STALL=1 in cycle 3, STALL=0 in cycle 4, BUSY_MASK[5]=0.
- x0 and masking: issue to x0, then read x0 → STALL=0, INFLIGHT=0. Issue x6 with SRC2_USE=0 and SRC2_ADR=6 → STALL=0.
- Multiple writers: issue x7 twice, then retire x7 once → BUSY_MASK[7]=1, INFLIGHT=1. Second retire → BUSY_MASK[7]=0, INFLIGHT=0.
- Simultaneous events: cnt[x8]=1, then issue x8 and retire x8 in the same cycle → cnt stays 1, INFLIGHT unchanged. Issue x9 while retiring x8 → x9 busy, x8 clear.
- Errors: 4 issues to x3 with no retire → cnt=3, INFLIGHT=3, ERR=1. Retire x10 at count 0 → ERR=1, INFLIGHT unchanged. Assert RST_N=0 mid-sequence → all outputs return to 0 immediately.
